// File: rtl/square_rebuild_if.sv
// Operand/result bundle for square_rebuild: the master drives the operands and
// start, and the slave (the datapath) returns status and the reconstructed value.
interface square_rebuild_if #(
  parameter int SIZE = 32
);
  logic              start;
  logic [SIZE-1:0]   root;
  logic [SIZE:0]     rem;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] num;
  logic              invalid;

  modport master (
    output start, root, rem,
    input  busy, done, num, invalid
  );

  modport slave (
    input  start, root, rem,
    output busy, done, num, invalid
  );
endinterface

// File: rtl/square_rebuild.sv
// Inverse integer square root: num = root*root + rem, built by shift-add with
// one root bit per cycle, plus a flag for (root, rem) pairs that no integer sqrt can produce.
module square_rebuild #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  square_rebuild_if.slave bus
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [SIZE-1:0]   root_q,    root_d;
  logic [2*SIZE-1:0] acc_q,     acc_d;
  logic [2*SIZE-1:0] num_q,     num_d;
  logic              invalid_q, invalid_d;
  logic [2*SIZE-1:0] addend;
  logic              last_step;

  // Partial product for the current bit; the sum wraps modulo 2^(2*SIZE).
  assign addend    = {{SIZE{1'b0}}, root_q} << cnt_q;
  assign last_step = (cnt_q == CW'(SIZE - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    root_d    = root_q;
    acc_d     = acc_q;
    num_d     = num_q;
    invalid_d = invalid_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          root_d    = bus.root;
          acc_d     = {{(SIZE - 1){1'b0}}, bus.rem};
          cnt_d     = '0;
          invalid_d = (bus.rem > {bus.root, 1'b0});
          state_d   = RUN;
        end
      end

      RUN: begin
        if (root_q[cnt_q]) begin
          acc_d = acc_q + addend;
        end
        if (last_step) begin
          cnt_d   = '0;
          num_d   = acc_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      root_q    <= '0;
      acc_q     <= '0;
      num_q     <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      root_q    <= root_d;
      acc_q     <= acc_d;
      num_q     <= num_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.num     = num_q;
  assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_square_rebuild.sv
// Directed bench for square_rebuild at SIZE=32: latency, reset abort, ignored
// restarts, operand sampling and back-to-back operation with start held high.
module tb_square_rebuild;

  localparam int SIZE = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  int          pulses;
  int          cyc;
  int          last_cyc;
  logic        seen;
  logic [63:0] got_num;
  logic [63:0] exp_num;
  logic        exp_inv;
  logic [31:0] vr [4];
  logic [32:0] vm [4];

  square_rebuild_if #(.SIZE(SIZE)) bus ();

  square_rebuild #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE; operands are scrambled right after acceptance.
  task automatic run_op(input logic [31:0] r, input logic [32:0] m,
                        input logic [63:0] en, input logic ei, input string tag);
    bus.start = 1'b1;
    bus.root  = r;
    bus.rem   = m;
    step();
    bus.start = 1'b0;
    bus.root  = ~r;
    bus.rem   = ~m;
    check({tag, "_busy_accept"}, 64'(bus.busy), 64'd1);
    check({tag, "_inv_accept"},  64'(bus.invalid), 64'(ei));
    repeat (SIZE - 1) step();
    check({tag, "_done_early"},  64'(bus.done), 64'd0);
    step();
    check({tag, "_done"},        64'(bus.done), 64'd1);
    check({tag, "_num"},         bus.num, en);
    check({tag, "_busy_done"},   64'(bus.busy), 64'd1);
    step();
    check({tag, "_done_drop"},   64'(bus.done), 64'd0);
    check({tag, "_busy_idle"},   64'(bus.busy), 64'd0);
    check({tag, "_num_hold"},    bus.num, en);
    check({tag, "_inv_hold"},    64'(bus.invalid), 64'(ei));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.root  = '0;
    bus.rem   = '0;

    #3;
    check("rst_busy",    64'(bus.busy), 64'd0);
    check("rst_done",    64'(bus.done), 64'd0);
    check("rst_num",     bus.num, 64'd0);
    check("rst_invalid", 64'(bus.invalid), 64'd0);

    // Release reset between edges; the very next edge must accept start.
    #9;
    rst_n = 1'b1;
    run_op(32'd5, 33'd3, 64'd28, 1'b0, "r5");
    run_op(32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "max");
    run_op(32'd3, 33'd7, 64'd16, 1'b1, "inv");

    // Restart during RUN must be ignored.
    bus.start = 1'b1;
    bus.root  = 32'd9;
    bus.rem   = 33'd0;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.start = 1'b1;
    bus.root  = 32'd2;
    bus.rem   = 33'd5;
    step();
    bus.start = 1'b0;
    pulses  = 0;
    got_num = '0;
    for (int i = 11; i <= 34; i++) begin
      step();
      if (i == 32) begin
        check("ign_done_edge32", 64'(bus.done), 64'd1);
      end
      if (bus.done === 1'b1) begin
        pulses++;
        got_num = bus.num;
      end
    end
    check("ign_pulses",  64'(pulses), 64'd1);
    check("ign_num",     got_num, 64'd81);
    check("ign_invalid", 64'(bus.invalid), 64'd0);

    // Reset mid-RUN aborts immediately with no done pulse.
    bus.start = 1'b1;
    bus.root  = 32'd100;
    bus.rem   = 33'd1;
    step();
    bus.start = 1'b0;
    repeat (14) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_num",  bus.num, 64'd0);
    check("abort_inv",  64'(bus.invalid), 64'd0);
    repeat (3) begin
      step();
      check("abort_hold_done", 64'(bus.done), 64'd0);
    end
    rst_n = 1'b1;
    run_op(32'd7, 33'd14, 64'd63, 1'b0, "post_rst");

    // Back-to-back with start held high; each pair is accepted 34 cycles apart.
    vr[0] = 32'h1234_5678; vm[0] = 33'h0_0000_0001;
    vr[1] = 32'h0000_0010; vm[1] = 33'h1_FFFF_FFFF;
    vr[2] = 32'hFFFF_FFFF; vm[2] = 33'h1_FFFF_FFFF;
    vr[3] = 32'h0000_0000; vm[3] = 33'h0_0000_0000;
    bus.root  = vr[0];
    bus.rem   = vm[0];
    bus.start = 1'b1;
    step();
    cyc      = 0;
    last_cyc = 0;
    for (int v = 0; v < 4; v++) begin
      if (v < 3) begin
        bus.root = vr[v + 1];
        bus.rem  = vm[v + 1];
      end
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        step();
        cyc++;
        if (bus.done === 1'b1) seen = 1'b1;
      end
      check("b2b_done_seen", 64'(seen), 64'd1);
      exp_num = {32'd0, vr[v]} * {32'd0, vr[v]} + {31'd0, vm[v]};
      exp_inv = ({1'b0, vm[v]} > ({2'b00, vr[v]} << 1));
      check("b2b_num",     bus.num, exp_num);
      check("b2b_invalid", 64'(bus.invalid), 64'(exp_inv));
      if (v > 0) begin
        check("b2b_spacing", 64'(cyc - last_cyc), 64'd34);
      end
      last_cyc = cyc;
      if (v < 3) begin
        step();
        step();
        cyc += 2;
      end else begin
        bus.start = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/square_rebuild.md
SQUARE_REBUILD -- requirements
Module: square_rebuild

Interface
REQ-001 Parameter: SIZE, default 32, root operand width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port start, input, 1 bit: request to begin a reconstruction.
REQ-006 Port root, input, SIZE bits: unsigned square root to be squared.
REQ-007 Port rem, input, SIZE+1 bits: unsigned remainder added to root squared.
REQ-008 Port busy, output, 1 bit: high while an operation is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking a valid num.
REQ-010 Port num, output, 2*SIZE bits: reconstructed value, root*root + rem.
REQ-011 Port invalid, output, 1 bit: high when the latched rem > 2*root, meaning the pair is not a legal integer-sqrt result.

Function
REQ-012 The block SHALL implement an inverse integer square root: num = root*root + rem, computed as a sequential shift-add with one root bit per cycle.
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL reset to IDLE.
REQ-014 IDLE with start=1 at a rising edge: latch root and rem; accumulator = rem zero-extended to 2*SIZE bits; bit counter = 0; invalid = (rem > {root,1'b0}); go to RUN.
REQ-015 IDLE with start=0: remain in IDLE; num and invalid hold their values.
REQ-016 Each RUN edge with latched root bit[counter] = 1: accumulator += latched root << counter, arithmetic modulo 2^(2*SIZE). The counter then increments.
REQ-017 RUN with counter = SIZE-1: perform the final step, copy the accumulator into num, go to DONE.
REQ-018 done SHALL be 1 only in DONE, so it is a single-cycle pulse. DONE SHALL go to IDLE unconditionally on the next edge.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 Latency: with start accepted at edge k, done is high during the cycle after edge k+SIZE, i.e. SIZE+1 cycles after acceptance. The next start can be accepted at edge k+SIZE+2.
REQ-021 start while busy=1 (RUN or DONE) SHALL be ignored and SHALL NOT disturb latched operands or the accumulator.
REQ-022 root and rem SHALL be sampled only at the accepting edge; later changes have no effect on the operation.
REQ-023 num SHALL update only on entry to DONE and hold until the next completion.
REQ-024 invalid SHALL update only at the accepting edge and hold until the next accepted start.
REQ-025 With invalid=1, num SHALL still equal (root*root + rem) mod 2^(2*SIZE). No saturation is applied.
REQ-026 For invalid=0 the true sum SHALL fit in 2*SIZE bits, since (2^SIZE-1)^2 + 2*(2^SIZE-1) = 2^(2*SIZE)-1.
REQ-027 root = 0 SHALL still take the full SIZE RUN cycles; there is no early termination.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force state = IDLE, busy = 0, done = 0, num = 0, invalid = 0, counter = 0, accumulator = 0 and latched operands = 0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse. After rst_n deasserts, the first start SHALL be accepted normally.
REQ-030 start sampled at the first rising edge after rst_n deasserts SHALL be accepted.

Verification (SIZE=32)
REQ-031 root=5, rem=3, start pulse at edge 0 -> busy=1 from edge 0; done=1 only in the cycle after edge 32; num=28; invalid=0.
REQ-032 root=0xFFFFFFFF, rem=0x1FFFFFFFE -> num=0xFFFFFFFFFFFFFFFF; invalid=0.
REQ-033 root=3, rem=7 -> num=16; invalid=1 from the accepting edge.
REQ-034 Start root=9, rem=0; at edge 10 raise start again with root=2 -> second start ignored; num=81 after 33 cycles; exactly one done pulse.
REQ-035 Start root=100, rem=1; pull rst_n low at cycle 15 -> all outputs 0 immediately with no done pulse. Then start root=7, rem=14 -> num=63, invalid=0.
REQ-036 Random root and rem, including rem > 2*root, back-to-back with start tied high -> each num matches the reference model mod 2^64; done pulses spaced exactly 34 cycles apart.
